mem_port_arbiter: RTL and testbench

Arbiter and request sequencer sitting directly upstream of the single unified byte-addressed memory of the pipelined RISC-V core. It multiplexes the IF-stage instruction fetch and the MEM-stage load/store onto the memory's one port. It checks alignment and range, and registers read data back to each requester with a valid pulse. It also generates the fetch-side stall.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every request, response and memory-port signal around the
// arbiter. Only clk and rst stay outside as plain ports.
//
// Handshake semantics: a requester raises if_req, or d_read/d_write, and holds
// it with stable address/data until the matching grant (if_gnt / d_gnt) is
// high in the same cycle. The transfer happens at the rising edge that ends
// the grant cycle. Results come back one cycle later as single-cycle pulses:
// *_valid with *_rdata for a legal read, or *_err for an illegal access.
// No backpressure exists on the result side.
//
// Modports:
//   slave  : the arbiter (takes requests and data_out, drives grants/results/memory port)
//   master : the environment (requesters plus memory)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_err;

  logic        d_read;
  logic        d_write;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;

  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_funct3, d_addr, d_wdata, data_out,
    output if_gnt, if_rdata, if_valid, if_err,
    output d_gnt, d_rdata, d_valid, d_err,
    output MemRead, MemWrite, funct3, addr, data_in
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_funct3, d_addr, d_wdata, data_out,
    input  if_gnt, if_rdata, if_valid, if_err,
    input  d_gnt, d_rdata, d_valid, d_err,
    input  MemRead, MemWrite, funct3, addr, data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter between the IF-stage fetch and the MEM-stage load/store for the
// single port of the unified byte-addressed memory.
// - Grants are combinational, with one winner per cycle. Data wins ties until
//   MAX_DATA_BURST consecutive data grants have gone by while a fetch waits.
// - Alignment and range are checked in the grant cycle. An illegal access is
//   still granted, but the memory enables are suppressed.
// - Read data is registered back to the requester with a one-cycle valid
//   pulse. An illegal access gives an err pulse instead.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_port_arbiter_if.slave (requests, grants, results, memory port)
module mem_port_arbiter #(
  parameter int MEM_BYTES      = 256,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [32:0] LIMIT     = 33'(MEM_BYTES);
  localparam logic [3:0]  BURST_MAX = 4'(MAX_DATA_BURST);

  logic [3:0]  burst_cnt;
  logic        burst_full;
  logic        d_req;
  logic        d_load;
  logic        if_win;
  logic        d_win;
  logic        fetch_bad;
  logic        d_bad;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_valid_q;
  logic        if_err_q;
  logic        d_valid_q;
  logic        d_err_q;

  // The sum is done in 33 bits so that addresses near 2^32 cannot wrap back
  // into range.
  function automatic logic beyond_end(input logic [31:0] a, input logic [1:0] last);
    return ({1'b0, a} + {31'b0, last}) >= LIMIT;
  endfunction

  assign d_req      = bus.d_read | bus.d_write;
  assign d_load     = bus.d_read & ~bus.d_write;  // read+write together counts as a write
  assign burst_full = (burst_cnt == BURST_MAX);
  assign if_win     = bus.if_req & (~d_req | burst_full);
  assign d_win      = d_req & ~(bus.if_req & burst_full);

  // Both grants are masked by rst, so nothing is granted while reset is held.
  assign bus.if_gnt = rst & if_win;
  assign bus.d_gnt  = rst & d_win;

  assign fetch_bad = (|bus.if_addr[1:0]) | beyond_end(bus.if_addr, 2'd3);

  always_comb begin
    d_bad = 1'b1;
    case (bus.d_funct3)
      3'b000:  d_bad = beyond_end(bus.d_addr, 2'd0);
      3'b100:  d_bad = bus.d_write | beyond_end(bus.d_addr, 2'd0);
      3'b001:  d_bad = bus.d_addr[0] | beyond_end(bus.d_addr, 2'd1);
      3'b101:  d_bad = bus.d_write | bus.d_addr[0] | beyond_end(bus.d_addr, 2'd1);
      3'b010:  d_bad = (|bus.d_addr[1:0]) | beyond_end(bus.d_addr, 2'd3);
      default: d_bad = 1'b1;
    endcase
  end

  // Memory port steering. With no grant the port is driven to all zeros.
  always_comb begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.funct3   = 3'b000;
    bus.addr     = 32'h0;
    bus.data_in  = 32'h0;
    if (bus.if_gnt) begin
      bus.MemRead = ~fetch_bad;
      bus.funct3  = 3'b010;
      bus.addr    = bus.if_addr;
    end else if (bus.d_gnt) begin
      bus.MemRead  = d_load & ~d_bad;
      bus.MemWrite = bus.d_write & ~d_bad;
      bus.funct3   = bus.d_funct3;
      bus.addr     = bus.d_addr;
      bus.data_in  = bus.d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      burst_cnt  <= 4'd0;
    end else begin
      if_valid_q <= bus.if_gnt & ~fetch_bad;
      if_err_q   <= bus.if_gnt & fetch_bad;
      d_valid_q  <= bus.d_gnt & d_load & ~d_bad;
      d_err_q    <= bus.d_gnt & d_bad;
      // data_out is captured only when MemRead was high in this cycle.
      if (bus.if_gnt && !fetch_bad) if_rdata_q <= bus.data_out;
      if (bus.d_gnt && d_load && !d_bad) d_rdata_q <= bus.data_out;
      // The counter tracks how long a waiting fetch has been bypassed.
      if (!bus.if_req || bus.if_gnt) burst_cnt <= 4'd0;
      else if (bus.d_gnt && !burst_full) burst_cnt <= burst_cnt + 4'd1;
    end
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_err   = if_err_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.d_err    = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It uses a byte-array memory model,
// per-cycle grant and memory-port checks, and scoreboard queues for the
// registered fetch and data results.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_BYTES(256), .MAX_DATA_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  logic [31:0] mw;

  always_comb begin
    ma = bus.addr[7:0];
    mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    bus.data_out = 32'hDEAD0BAD;  // junk whenever the port is not reading
    if (bus.MemRead) begin
      case (bus.funct3)
        3'b000:  bus.data_out = {{24{mw[7]}}, mw[7:0]};
        3'b100:  bus.data_out = {24'h0, mw[7:0]};
        3'b001:  bus.data_out = {{16{mw[15]}}, mw[15:0]};
        3'b101:  bus.data_out = {16'h0, mw[15:0]};
        default: bus.data_out = mw;
      endcase
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h11223344;
    {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'hCAFEF00D;
    forever begin
      @(posedge clk);
      if (bus.MemWrite) begin
        case (bus.funct3)
          3'b000: mem[bus.addr[7:0]] = bus.data_in[7:0];
          3'b001: {mem[bus.addr[7:0] + 8'd1], mem[bus.addr[7:0]]} = bus.data_in[15:0];
          default: {mem[bus.addr[7:0] + 8'd3], mem[bus.addr[7:0] + 8'd2],
                    mem[bus.addr[7:0] + 8'd1], mem[bus.addr[7:0]]} = bus.data_in;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Each entry is {valid, err, rdata}.
  logic [33:0] exp_if_q[$];
  logic [33:0] exp_d_q[$];
  logic [31:0] last_if;
  logic [31:0] last_d;
  int checks;
  int failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_if(input logic v, input logic e, input logic [31:0] r);
    exp_if_q.push_back({v, e, r});
    if (v) last_if = r;
  endtask

  task automatic push_d(input logic v, input logic e, input logic [31:0] r);
    exp_d_q.push_back({v, e, r});
    if (v) last_d = r;
  endtask

  // Monitor: pops an expected result whenever the DUT shows a result pulse.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst && (bus.if_valid || bus.if_err)) begin
        if (exp_if_q.size() == 0) check("if_unexpected", {bus.if_valid, bus.if_err, bus.if_rdata}, 64'h0);
        else begin
          e = exp_if_q.pop_front();
          check("if_result", {bus.if_valid, bus.if_err, bus.if_rdata}, e);
        end
      end
      if (rst && (bus.d_valid || bus.d_err)) begin
        if (exp_d_q.size() == 0) check("d_unexpected", {bus.d_valid, bus.d_err, bus.d_rdata}, 64'h0);
        else begin
          e = exp_d_q.pop_front();
          check("d_result", {bus.d_valid, bus.d_err, bus.d_rdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_if(input logic req, input logic [31:0] a);
    bus.if_req  = req;
    bus.if_addr = a;
  endtask

  task automatic set_d(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.d_read   = rd;
    bus.d_write  = wr;
    bus.d_funct3 = f3;
    bus.d_addr   = a;
    bus.d_wdata  = wd;
  endtask

  // Checks the grant cycle mid-cycle, then steps to just after the next edge.
  task automatic drive_cycle(input string name, input logic e_ig, input logic e_dg,
                             input logic e_mr, input logic e_mw, input logic [2:0] e_f3,
                             input logic [31:0] e_addr, input logic [31:0] e_wd);
    @(negedge clk);
    check({name, ":ctl"}, {bus.if_gnt, bus.d_gnt, bus.MemRead, bus.MemWrite, bus.funct3},
          {e_ig, e_dg, e_mr, e_mw, e_f3});
    check({name, ":addr"}, bus.addr, e_addr);
    check({name, ":data_in"}, bus.data_in, e_wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    set_if(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive_cycle(name, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] fetch_slot;

  initial begin
    checks = 0;
    failures = 0;
    last_if = 32'h0;
    last_d = 32'h0;
    fetch_slot = 8'b0001_0000;  // cycle 4 (0-based) is the forced fetch

    // Reset: both requesters are asking, but nothing may be granted.
    rst = 1'b0;
    set_if(1'b1, 32'h10);
    set_d(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    check("rst_gnt", {bus.if_gnt, bus.d_gnt, bus.MemRead, bus.MemWrite}, 4'b0000);
    check("rst_out", {bus.if_valid, bus.if_err, bus.d_valid, bus.d_err, bus.if_rdata, bus.d_rdata}, 68'h0);
    set_if(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: single fetch.
    set_if(1'b1, 32'h10);
    push_if(1'b1, 1'b0, 32'h11223344);
    drive_cycle("t1_fetch", 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    idle("t1_idle");

    // Test 2: store word, then load it back; store byte and sub-word loads.
    set_d(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    drive_cycle("t2_sw", 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    set_d(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    push_d(1'b1, 1'b0, 32'hDEADBEEF);
    drive_cycle("t2_lw", 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    set_d(1'b1, 1'b0, 3'b100, 32'h23, 32'h0);
    push_d(1'b1, 1'b0, 32'h000000DE);
    drive_cycle("t2_lbu", 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 32'h23, 32'h0);
    set_d(1'b1, 1'b0, 3'b000, 32'h23, 32'h0);
    push_d(1'b1, 1'b0, 32'hFFFFFFDE);
    drive_cycle("t2_lb", 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h23, 32'h0);
    set_d(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    push_d(1'b1, 1'b0, 32'hFFFFDEAD);
    drive_cycle("t2_lh", 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    set_d(1'b0, 1'b1, 3'b000, 32'h30, 32'h123456A5);
    drive_cycle("t2_sb", 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h30, 32'h123456A5);
    set_d(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    push_d(1'b1, 1'b0, 32'h000000A5);
    drive_cycle("t2_lw_sb", 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    idle("t2_idle");

    // Test 3: contention with MAX_DATA_BURST=4 gives D,D,D,D,F,D,D,D.
    set_if(1'b1, 32'h10);
    set_d(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (fetch_slot[i]) begin
        push_if(1'b1, 1'b0, 32'h11223344);
        drive_cycle($sformatf("t3_c%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      end else begin
        push_d(1'b1, 1'b0, 32'hDEADBEEF);
        drive_cycle($sformatf("t3_c%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      end
    end
    idle("t3_idle");

    // Fetch range and alignment boundaries.
    set_if(1'b1, 32'hFC);
    push_if(1'b1, 1'b0, 32'hCAFEF00D);
    drive_cycle("f_fc", 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'hFC, 32'h0);
    set_if(1'b1, 32'h100);
    push_if(1'b0, 1'b1, last_if);
    drive_cycle("f_100", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    set_if(1'b1, 32'h12);
    push_if(1'b0, 1'b1, last_if);
    drive_cycle("f_mis", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h12, 32'h0);
    set_if(1'b1, 32'hFFFFFFFC);
    push_if(1'b0, 1'b1, last_if);
    drive_cycle("f_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);
    idle("f_idle");

    // Data boundaries at the top of memory.
    set_d(1'b1, 1'b0, 3'b101, 32'hFE, 32'h0);
    push_d(1'b1, 1'b0, 32'h0000CAFE);
    drive_cycle("d_lhu_fe", 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 32'hFE, 32'h0);
    set_d(1'b1, 1'b0, 3'b000, 32'hFF, 32'h0);
    push_d(1'b1, 1'b0, 32'hFFFFFFCA);
    drive_cycle("d_lb_ff", 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'hFF, 32'h0);

    // Test 4: illegal data accesses are granted with no enables and give an err pulse.
    set_d(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    push_d(1'b0, 1'b1, last_d);
    drive_cycle("t4_lw_mis", 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h22, 32'h0);
    set_d(1'b1, 1'b0, 3'b001, 32'h21, 32'h0);
    push_d(1'b0, 1'b1, last_d);
    drive_cycle("t4_lh_mis", 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h21, 32'h0);
    set_d(1'b1, 1'b0, 3'b000, 32'h100, 32'h0);
    push_d(1'b0, 1'b1, last_d);
    drive_cycle("t4_lb_oor", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h0);
    set_d(1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
    push_d(1'b0, 1'b1, last_d);
    drive_cycle("t4_ld_f3", 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 32'h20, 32'h0);
    set_d(1'b0, 1'b1, 3'b100, 32'h30, 32'hFFFFFFFF);
    push_d(1'b0, 1'b1, last_d);
    drive_cycle("t4_st_f3", 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 32'h30, 32'hFFFFFFFF);
    set_d(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    push_d(1'b1, 1'b0, 32'h000000A5);
    drive_cycle("t4_unchanged", 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    idle("t4_idle");

    // Test 5: reset asserted in the middle of the result cycle.
    set_if(1'b1, 32'h10);
    drive_cycle("t5_fetch", 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("t5_valid_before", {bus.if_valid, bus.if_rdata}, {1'b1, 32'h11223344});
    set_if(1'b0, 32'h0);
    #2;
    rst = 1'b0;
    exp_if_q.delete();
    exp_d_q.delete();
    last_if = 32'h0;
    last_d = 32'h0;
    @(negedge clk);
    check("t5_rst_if", {bus.if_valid, bus.if_err, bus.if_rdata}, 34'h0);
    check("t5_rst_d", {bus.d_valid, bus.d_err, bus.d_rdata}, 34'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle("t5_idle0");
    idle("t5_idle1");
    check("t5_no_stale", {bus.if_valid, bus.if_err}, 2'b00);
    set_d(1'b1, 1'b0, 3'b110, 32'h20, 32'h0);
    push_d(1'b0, 1'b1, 32'h0);
    drive_cycle("t5_d_err", 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 32'h20, 32'h0);
    idle("t5_idle2");
    idle("t5_idle3");

    check("if_q_drained", 64'(exp_if_q.size()), 64'h0);
    check("d_q_drained", 64'(exp_d_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
